// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// vga_timing_gen : parametrised VGA raster timing (sync, DE, coords, strobes).
// Option macro VGA_TIMING_FRAME_CNT_EN enables the completed-frame counter.
// Revision: 1.0
// ============================================================================
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CLK_DIV  = 1,
  parameter int FC_W     = 8,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1,
  localparam int VW      = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ena,
  output logic            hsync,
  output logic            vsync,
  output logic            display_on,
  output logic [HW-1:0]   hpos,
  output logic [VW-1:0]   vpos,
  output logic            pix_stb,
  output logic            line_start,
  output logic            frame_start,
  output logic [FC_W-1:0] frame_cnt
);

  localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;

  localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [HW-1:0]    C_H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0]    C_V_LAST   = VW'(V_TOTAL - 1);

  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] w_div_nxt;
  logic             w_div_wrap;
  logic             w_h_wrap;
  logic             w_v_wrap;
  logic [HW-1:0]    w_hpos_nxt;
  logic [VW-1:0]    w_vpos_nxt;
  logic             w_hs_act;
  logic             w_vs_act;
  logic             w_de_nxt;

  // Sync and display-enable are decoded from the next counts so the registered
  // levels line up with the registered coordinates.
  always_comb begin
    w_div_wrap = (r_div == C_DIV_LAST);
    w_div_nxt  = w_div_wrap ? '0 : r_div + DIV_W'(1);
    w_h_wrap   = w_div_wrap && (hpos == C_H_LAST);
    w_v_wrap   = w_h_wrap && (vpos == C_V_LAST);
    w_hpos_nxt = hpos;
    w_vpos_nxt = vpos;
    if (w_div_wrap) begin
      w_hpos_nxt = w_h_wrap ? '0 : hpos + HW'(1);
      if (w_h_wrap) begin
        w_vpos_nxt = w_v_wrap ? '0 : vpos + VW'(1);
      end
    end
    w_hs_act = (int'(w_hpos_nxt) >= HS_START) && (int'(w_hpos_nxt) < HS_END);
    w_vs_act = (int'(w_vpos_nxt) >= VS_START) && (int'(w_vpos_nxt) < VS_END);
    w_de_nxt = (int'(w_hpos_nxt) < H_ACTIVE) && (int'(w_vpos_nxt) < V_ACTIVE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div       <= '0;
      hpos        <= '0;
      vpos        <= '0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      display_on  <= 1'b1;
      pix_stb     <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pix_stb     <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (ena) begin
        r_div   <= w_div_nxt;
        pix_stb <= w_div_wrap;
        if (w_div_wrap) begin
          hpos        <= w_hpos_nxt;
          vpos        <= w_vpos_nxt;
          hsync       <= w_hs_act ? HS_POL : ~HS_POL;
          vsync       <= w_vs_act ? VS_POL : ~VS_POL;
          display_on  <= w_de_nxt;
          line_start  <= w_h_wrap;
          frame_start <= w_v_wrap;
        end
      end
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (ena && w_v_wrap) begin
      frame_cnt <= frame_cnt + FC_W'(1);
    end
  end
`else
  assign frame_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// Scoreboard bench for vga_timing_gen: small 14x8 mode at CLK_DIV 1 and 3.
module tb_vga_timing_gen;

  localparam int HT = 14;
  localparam int VT = 8;
  localparam int FT = HT * VT;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b0;
  always #5 clk = ~clk;

  logic       d1_hs, d1_vs, d1_de, d1_stb, d1_ls, d1_fs;
  logic [3:0] d1_hpos;
  logic [2:0] d1_vpos;
  logic [7:0] d1_fc;
  logic       d3_hs, d3_vs, d3_de, d3_stb, d3_ls, d3_fs;
  logic [3:0] d3_hpos;
  logic [2:0] d3_vpos;
  logic [7:0] d3_fc;

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .CLK_DIV(1), .FC_W(8)
  ) u_d1 (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .hsync(d1_hs), .vsync(d1_vs), .display_on(d1_de),
    .hpos(d1_hpos), .vpos(d1_vpos), .pix_stb(d1_stb),
    .line_start(d1_ls), .frame_start(d1_fs), .frame_cnt(d1_fc)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .CLK_DIV(3), .FC_W(8)
  ) u_d3 (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .hsync(d3_hs), .vsync(d3_vs), .display_on(d3_de),
    .hpos(d3_hpos), .vpos(d3_vpos), .pix_stb(d3_stb),
    .line_start(d3_ls), .frame_start(d3_fs), .frame_cnt(d3_fc)
  );

  typedef struct packed {
    logic [3:0] hpos;
    logic [2:0] vpos;
    logic       hs, vs, de, stb, ls, fs;
    logic [7:0] fc;
  } vec_t;

  vec_t q1[$];
  vec_t q3[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   n = 0;            // enabled clock edges since reset release
  logic edge_en = 1'b0;
  int   fs1_cnt = 0;
  int   fs3_cnt = 0;
  vec_t e_v, a_v;

  // Expected outputs after nn enabled edges, derived from raster arithmetic.
  function automatic vec_t expect_at(input int nn, input int div, input logic en_edge);
    vec_t v;
    int   pix;
    pix    = (nn / div) % FT;
    v.hpos = 4'(pix % HT);
    v.vpos = 3'(pix / HT);
    v.hs   = !((v.hpos >= 10) && (v.hpos < 13));
    v.vs   = !((v.vpos >= 5) && (v.vpos < 7));
    v.de   = (v.hpos < 8) && (v.vpos < 4);
    v.stb  = en_edge && (nn % div == 0);
    v.ls   = v.stb && (pix % HT == 0);
    v.fs   = v.stb && (pix == 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
    v.fc   = 8'(nn / (div * FT));
`else
    v.fc   = 8'd0;
`endif
    return v;
  endfunction

  task automatic step(input logic en);
    ena = en;
    @(posedge clk);
    #1;
    if (rst_n && en) begin
      n++;
      edge_en = 1'b1;
    end else begin
      edge_en = 1'b0;
    end
    q1.push_back(expect_at(n, 1, edge_en));
    q3.push_back(expect_at(n, 3, edge_en));
  endtask

  always @(negedge clk) begin
    if (d1_fs) fs1_cnt++;
    if (d3_fs) fs3_cnt++;
    if (q1.size() > 0 && q3.size() > 0) begin
      e_v = q1.pop_front();
      a_v = {d1_hpos, d1_vpos, d1_hs, d1_vs, d1_de, d1_stb, d1_ls, d1_fs, d1_fc};
      vectors++;
      if (a_v !== e_v) begin
        miscompares++;
        $display("FAIL div1_vec n=%0d: got %h expected %h", n, a_v, e_v);
      end
      e_v = q3.pop_front();
      a_v = {d3_hpos, d3_vpos, d3_hs, d3_vs, d3_de, d3_stb, d3_ls, d3_fs, d3_fc};
      vectors++;
      if (a_v !== e_v) begin
        miscompares++;
        $display("FAIL div3_vec n=%0d: got %h expected %h", n, a_v, e_v);
      end
    end
  end

  task automatic check_int(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    vec_t a1, e1;
    rst_n = 1'b0;
    ena   = 1'b0;
    repeat (3) step(1'b1);
    rst_n = 1'b1;
    repeat (6) step(1'b1);          // hpos reaches 6 on the div-1 instance
    repeat (5) step(1'b0);          // freeze: hold position, no strobes
    while (n < 415) step(1'b1);     // 415 mod 112 = 79 -> hpos 9, vpos 5
    #6;
    rst_n = 1'b0;                   // between clock edges
    #1;
    a1 = {d1_hpos, d1_vpos, d1_hs, d1_vs, d1_de, d1_stb, d1_ls, d1_fs, d1_fc};
    e1 = expect_at(0, 1, 1'b0);
    vectors++;
    if (a1 !== e1) begin
      miscompares++;
      $display("FAIL async_reset: got %h expected %h", a1, e1);
    end
    n = 0;
    repeat (2) step(1'b1);
    rst_n = 1'b1;
    repeat (50) step(1'b1);
    @(negedge clk);
    @(negedge clk);
    check_int("queue_drained", q1.size() + q3.size(), 0);
    check_int("div1_frame_starts", fs1_cnt, 3);
    check_int("div3_frame_starts", fs3_cnt, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
